// File: rtl/btn_fltr_bank_if.sv
// btn_fltr_bank_if: raw button inputs, enable tick and filtered event outputs.
// The slave side is the filter bank, the master side is the pin/test driver.
interface btn_fltr_bank_if #(
  parameter int CHANNELS = 4
);
  logic                ce;
  logic [CHANNELS-1:0] in_signal;
  logic [CHANNELS-1:0] OUT_SIGNAL;
  logic [CHANNELS-1:0] OUT_PRESS;
  logic [CHANNELS-1:0] OUT_RELEASE;
  logic [CHANNELS-1:0] OUT_LONG;

  modport master (
    output ce,
    output in_signal,
    input  OUT_SIGNAL,
    input  OUT_PRESS,
    input  OUT_RELEASE,
    input  OUT_LONG
  );

  modport slave (
    input  ce,
    input  in_signal,
    output OUT_SIGNAL,
    output OUT_PRESS,
    output OUT_RELEASE,
    output OUT_LONG
  );
endinterface

// File: rtl/btn_fltr_bank.sv
// btn_fltr_bank: per-channel synchroniser, stability filter and event pulses.
// A shared ce tick qualifies all stability and long-press counting.
module btn_fltr_bank #(
  parameter int   CHANNELS    = 4,
  parameter int   STABLE_CNT  = 4,
  parameter int   LONG_CNT    = 0,
  parameter logic RESET_LEVEL = 1'b0
) (
  input logic            clk,
  input logic            rst,
  btn_fltr_bank_if.slave bus
);
  localparam int SCW = $clog2(STABLE_CNT + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(STABLE_CNT - 1);
  localparam logic [SCW-1:0] SC_ONE  = SCW'(1);

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [CHANNELS-1:0] lvl_q;
  logic [CHANNELS-1:0] press_q;
  logic [CHANNELS-1:0] rel_q;
  logic [CHANNELS-1:0] long_q;
  logic [SCW-1:0]      sc [CHANNELS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= {CHANNELS{RESET_LEVEL}};
      s2      <= {CHANNELS{RESET_LEVEL}};
      lvl_q   <= {CHANNELS{RESET_LEVEL}};
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        sc[i] <= '0;
      end
    end else begin
      s1      <= bus.in_signal;
      s2      <= s1;
      press_q <= '0;
      rel_q   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        // any sample matching the current level restarts the count
        if (s2[i] == lvl_q[i]) begin
          sc[i] <= '0;
        end else if (bus.ce) begin
          if (sc[i] == SC_LAST) begin
            lvl_q[i]   <= s2[i];
            sc[i]      <= '0;
            press_q[i] <= s2[i];
            rel_q[i]   <= ~s2[i];
          end else begin
            sc[i] <= sc[i] + SC_ONE;
          end
        end
      end
    end
  end

  if (LONG_CNT > 0) begin : g_long
    localparam int HCW = $clog2(LONG_CNT + 1);
    localparam logic [HCW-1:0] HC_MAX = HCW'(LONG_CNT);
    localparam logic [HCW-1:0] HC_PRE = HCW'(LONG_CNT - 1);
    localparam logic [HCW-1:0] HC_ONE = HCW'(1);

    logic [HCW-1:0] hc [CHANNELS];

    always_ff @(posedge clk) begin
      if (rst) begin
        long_q <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          hc[i] <= '0;
        end
      end else begin
        long_q <= '0;
        for (int i = 0; i < CHANNELS; i++) begin
          // saturation at HC_MAX keeps it to one pulse per press
          if (!lvl_q[i]) begin
            hc[i] <= '0;
          end else if (bus.ce && hc[i] != HC_MAX) begin
            hc[i]     <= hc[i] + HC_ONE;
            long_q[i] <= (hc[i] == HC_PRE);
          end
        end
      end
    end
  end else begin : g_no_long
    assign long_q = '0;
  end

  assign bus.OUT_SIGNAL  = lvl_q;
  assign bus.OUT_PRESS   = press_q;
  assign bus.OUT_RELEASE = rel_q;
  assign bus.OUT_LONG    = long_q;
endmodule

// File: tb/tb_btn_fltr_bank.sv
// tb_btn_fltr_bank: directed plus random stimulus, reference model feeds
// a queue of expected output bundles that a negedge monitor consumes.
module tb_btn_fltr_bank;
  localparam int CH = 4;
  localparam int SC = 4;
  localparam int LC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  btn_fltr_bank_if #(.CHANNELS(CH)) bus ();

  btn_fltr_bank #(
    .CHANNELS   (CH),
    .STABLE_CNT (SC),
    .LONG_CNT   (LC),
    .RESET_LEVEL(1'b0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] sig;
    logic [CH-1:0] prs;
    logic [CH-1:0] rls;
    logic [CH-1:0] lng;
  } obs_t;

  obs_t exp_q[$];
  int   checks  = 0;
  int   passes  = 0;
  int   ce_mode = 0;
  int   cyc     = 0;

  // reference model: input delayed two clocks, then counted acceptance
  bit m_lvl [CH];
  bit m_p1  [CH];
  bit m_p2  [CH];
  int m_run [CH];
  int m_hold[CH];

  always @(posedge clk) begin
    obs_t e;
    bit   was;
    e = '0;
    for (int i = 0; i < CH; i++) begin
      if (rst) begin
        m_lvl[i]  = 1'b0;
        m_p1[i]   = 1'b0;
        m_p2[i]   = 1'b0;
        m_run[i]  = 0;
        m_hold[i] = 0;
      end else begin
        was = m_lvl[i];
        if (!was) m_hold[i] = 0;
        else if (bus.ce && m_hold[i] < LC) begin
          m_hold[i]++;
          if (m_hold[i] == LC) e.lng[i] = 1'b1;
        end
        if (m_p2[i] == was) m_run[i] = 0;
        else if (bus.ce) begin
          m_run[i]++;
          if (m_run[i] == SC) begin
            m_lvl[i] = m_p2[i];
            m_run[i] = 0;
            e.prs[i] = m_p2[i];
            e.rls[i] = !m_p2[i];
          end
        end
        m_p2[i] = m_p1[i];
        m_p1[i] = bus.in_signal[i];
      end
      e.sig[i] = m_lvl[i];
    end
    exp_q.push_back(e);
  end

  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {bus.OUT_SIGNAL, bus.OUT_PRESS, bus.OUT_RELEASE, bus.OUT_LONG};
      checks++;
      if (a === e) passes++;
      else $display("FAIL scoreboard t=%0t got %h exp %h", $time, a, e);
      checks++;
      if ((a.prs & a.rls) === '0 && (a.prs & a.lng) === '0) passes++;
      else $display("FAIL exclusive t=%0t prs %b rls %b lng %b exp no overlap",
                    $time, a.prs, a.rls, a.lng);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ce_mode)
      0:       bus.ce = 1'b1;
      1:       bus.ce = (cyc % 3 == 0);
      default: bus.ce = 1'($urandom_range(0, 1));
    endcase
  endtask

  function automatic bit pulse(input int kind, input int ch);
    case (kind)
      0:       return bus.OUT_PRESS[ch];
      1:       return bus.OUT_RELEASE[ch];
      default: return bus.OUT_LONG[ch];
    endcase
  endfunction

  task automatic wait_pulse(input string nm, input int kind, input int ch,
                            input int exp_n);
    int n    = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = pulse(kind, ch);
    end
    checks++;
    if (seen && n == exp_n) passes++;
    else $display("FAIL %s latency got %0d seen %0b exp %0d", nm, n, seen, exp_n);
  endtask

  initial begin
    bus.ce        = 1'b1;
    bus.in_signal = '0;
    repeat (3) tick();
    rst = 1'b0;

    // clean press on ch0
    bus.in_signal = 4'b0001;
    wait_pulse("press0", 0, 0, 6);
    repeat (12) tick();
    bus.in_signal = 4'b0000;
    wait_pulse("release0", 1, 0, 6);
    repeat (4) tick();

    // bounce on ch1: 1,1,1,0 then steady high
    bus.in_signal[1] = 1'b1;
    repeat (3) tick();
    bus.in_signal[1] = 1'b0;
    tick();
    bus.in_signal[1] = 1'b1;
    wait_pulse("press1_bounce", 0, 1, 6);
    repeat (4) tick();
    bus.in_signal[1] = 1'b0;
    repeat (16) tick();

    // long press on ch2, release, short re-press
    bus.in_signal[2] = 1'b1;
    wait_pulse("press2", 0, 2, 6);
    wait_pulse("long2", 2, 2, 8);
    repeat (6) tick();
    bus.in_signal[2] = 1'b0;
    wait_pulse("release2", 1, 2, 6);
    bus.in_signal[2] = 1'b1;
    repeat (5) tick();
    bus.in_signal[2] = 1'b0;
    repeat (20) tick();

    // sparse enable on ch3
    ce_mode = 1;
    bus.in_signal[3] = 1'b1;
    repeat (30) tick();
    bus.in_signal[3] = 1'b0;
    repeat (30) tick();
    ce_mode = 0;
    repeat (3) tick();

    // reset while ch0 is mid-debounce
    bus.in_signal[0] = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_pulse("press0_after_rst", 0, 0, 6);
    bus.in_signal[0] = 1'b0;
    repeat (10) tick();

    // all channels together
    bus.in_signal = 4'b1111;
    repeat (20) tick();
    bus.in_signal = 4'b0000;
    repeat (12) tick();

    // random traffic with random enable and occasional reset
    ce_mode = 2;
    for (int blk = 0; blk < 12; blk++) begin
      int div;
      div = ($urandom_range(0, 1) != 0) ? 3 : 24;
      for (int k = 0; k < 200; k++) begin
        for (int c = 0; c < CH; c++) begin
          if ($urandom_range(0, div - 1) == 0) bus.in_signal[c] = ~bus.in_signal[c];
        end
        rst = ($urandom_range(0, 399) == 0);
        tick();
      end
    end
    rst = 1'b0;
    ce_mode = 0;
    repeat (20) tick();
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/btn_fltr_bank.md
# btn_fltr_bank

Multi-channel debounce filter with edge and long-press event outputs. Each of `CHANNELS` asynchronous button/switch inputs is synchronised, then filtered by a per-channel stability counter gated by a shared clock-enable tick. Each channel produces a debounced level, one-cycle press and release pulses, and a one-cycle long-press pulse. The block sits between the board pins and the LED/mode control logic and replaces per-button single-channel filters.

## Interface

Parameters:
- `CHANNELS`, 4: number of independent input channels, ≥1.
- `STABLE_CNT`, 4: consecutive enabled ticks a new level must persist before it is accepted. Range 1..65535. Counter width is `$clog2(STABLE_CNT+1)`.
- `LONG_CNT`, 0: enabled ticks the debounced level must stay high before `OUT_LONG` fires. 0 disables long-press detection (`OUT_LONG` tied 0). Counter width is `$clog2(LONG_CNT+1)`.
- `RESET_LEVEL`, 1'b0: debounced level loaded into every channel on reset. Also the synchroniser reset value.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ce` in 1: clock-enable tick that qualifies counting. Tie to 1 for per-clock counting.
- `in_signal` in `CHANNELS`: raw asynchronous inputs, one bit per channel.
- `OUT_SIGNAL` out `CHANNELS`: debounced level.
- `OUT_PRESS` out `CHANNELS`: one-clk pulse on a debounced 0→1 transition.
- `OUT_RELEASE` out `CHANNELS`: one-clk pulse on a debounced 1→0 transition.
- `OUT_LONG` out `CHANNELS`: one-clk pulse when the debounced level has been high for `LONG_CNT` enabled ticks.

## Operation

Channels are fully independent. Per channel:
- **Synchroniser:** 2-flop chain on `in_signal[i]`. Output `s`. Runs every clk, independent of `ce`.
- **Stability counter `sc`:**
  - If `s == OUT_SIGNAL[i]`, `sc` clears to 0 every clk, whether or not `ce` is high (glitch rejection).
  - Otherwise, if `ce` is high and `sc == STABLE_CNT-1`: `OUT_SIGNAL[i] <= s` and `sc <= 0`. On the same edge, `OUT_PRESS[i]` (if `s`=1) or `OUT_RELEASE[i]` (if `s`=0) is registered high.
  - Otherwise, if `ce` is high: `sc <= sc+1`.
  - Otherwise: `sc` holds.
- **Hold counter `hc`** (only when `LONG_CNT > 0`):
  - Clears whenever `OUT_SIGNAL[i]` = 0.
  - While `OUT_SIGNAL[i]` = 1 and `ce` is high, increments and saturates at `LONG_CNT`.
  - `OUT_LONG[i]` is registered high on the edge where `hc` goes from `LONG_CNT-1` to `LONG_CNT`.
  - It fires once per press. It re-arms only after a debounced release.
- **Pulse outputs:** `OUT_PRESS`, `OUT_RELEASE` and `OUT_LONG` are high for exactly one clk, then return to 0. They are not held for the duration of `ce` low.
- **Reset:**
  - Synchroniser flops and `OUT_SIGNAL` go to `RESET_LEVEL`.
  - `sc`, `hc` and all pulse outputs go to 0.
  - No press or release pulse is generated by reset itself.
  - Reset mid-debounce discards partial counts.
  - If `RESET_LEVEL`=1, `hc` starts counting from 0 after reset.

## Timing

- **Reset values:** `OUT_SIGNAL` = {CHANNELS{RESET_LEVEL}}. `OUT_PRESS`, `OUT_RELEASE` and `OUT_LONG` = 0.
- **Debounce latency (`ce`=1):** input changes before edge E0 and then stays stable. Edges E1–E2 are synchroniser delay. `OUT_SIGNAL` and the matching edge pulse update at edge E(2+STABLE_CNT).
- **Debounce latency with a sparse `ce`:** 2 clks, then `STABLE_CNT` enabled ticks.
- **Long-press latency (`ce`=1):** press registered at edge P gives `OUT_LONG` high at edge P+LONG_CNT.
- **Bounce handling:** a bounce back to the current level for one or more clks resets `sc`. Acceptance requires `STABLE_CNT` uninterrupted enabled ticks.
- **Simultaneous events:**
  - Different channels may pulse on the same clk.
  - `OUT_PRESS` and `OUT_RELEASE` are never high together on one channel.
  - `OUT_LONG` never coincides with `OUT_PRESS` for the same channel, because `LONG_CNT` ≥ 1.
- **Release before long-press:** a release before `hc` reaches `LONG_CNT` suppresses `OUT_LONG`.

## Test plan

Settings: `CHANNELS`=4, `STABLE_CNT`=4, `LONG_CNT`=8, `RESET_LEVEL`=0, `ce`=1 unless stated.

1. **Reset, then clean press:** hold `rst` 3 clks with inputs at 0, then set `in_signal`=4'b0001 after reset. Outputs are 0 during and after reset. `OUT_SIGNAL[0]`=1 and `OUT_PRESS[0]` pulses exactly 6 clks after the input edge. Channels 1–3 stay silent.
2. **Bounce rejection:** toggle ch1 as 1,1,1,0,1,1,1,1 per clk. No event at the first three-clk run. `OUT_PRESS[1]` fires 6 clks after the final rise.
3. **Long press, then release:** hold ch2 high for 20 clks. `OUT_PRESS[2]` fires, then `OUT_LONG[2]` fires 8 clks later exactly once. On release, `OUT_RELEASE[2]` fires 6 clks after the input falls. A short re-press of 5 clks produces no `OUT_LONG`.
4. **Sparse enable:** `ce` high every 3rd clk, ch3 rises. `OUT_SIGNAL[3]` updates after 2 clks plus 4 enabled ticks. `OUT_PRESS[3]` is exactly 1 clk wide.
5. **Reset mid-debounce:** raise ch0, assert `rst` 1 clk at count 2, keep input high. No pulse during reset. Press is accepted 4 enabled ticks after reset deasserts, with the synchroniser now reloaded.
6. **Simultaneous channels:** all four inputs rise on one clk. All four `OUT_PRESS` bits pulse on the same clk, and all four `OUT_LONG` bits pulse 8 clks later.
